prog_loader: RTL and testbench

//  Writer side of the CPU instruction-memory interface. Receives a program as a byte

---
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Loads a byte-streamed program into instruction memory with the CPU held in reset,
// then releases the CPU and counts run cycles until it reports halted.
module prog_loader #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8,
  parameter int CYC_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [ADDR_W:0]    num_instr,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_rst,
  input  logic               halted,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CYC_W-1:0]   run_cycles
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    WRITE   = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_N   = {{ADDR_W{1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [ADDR_W:0]      n_lat;
  logic [ADDR_W-1:0]    cnt;
  logic [7:0]           lo_byte, hi_byte;
  logic [ADDR_W-1:0]    last_addr;
  logic [INSTR_W-1:0]   last_wdata;
  logic [CYC_W-1:0]     run_cnt;
  logic                 err_q;

  logic n_ok;
  logic last_word;
  logic accept_start;
  logic reject_start;

  assign n_ok      = (num_instr != '0) && (num_instr <= DEPTH_N);
  assign last_word = ({1'b0, cnt} == (n_lat - ONE_N));

  always_comb begin
    state_n      = state;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    cpu_rst      = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    accept_start = 1'b0;
    reject_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_ok) begin
            accept_start = 1'b1;
            state_n      = LOAD_LO;
          end else begin
            reject_start = 1'b1;
          end
        end
      end
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (start) begin
          if (n_ok) begin
            accept_start = 1'b1;
            state_n      = LOAD_LO;
          end else begin
            reject_start = 1'b1;
            state_n      = IDLE;
          end
        end
      end
      LOAD_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_n = LOAD_HI;
      end
      LOAD_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_n = WRITE;
      end
      WRITE: begin
        mem_we  = 1'b1;
        busy    = 1'b1;
        state_n = last_word ? RUN : LOAD_LO;
      end
      RUN: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
        if (halted) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers; memory contents are outside this block and survive RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      n_lat      <= '0;
      cnt        <= '0;
      lo_byte    <= '0;
      hi_byte    <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
      run_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept_start) begin
        n_lat   <= num_instr;
        cnt     <= '0;
        run_cnt <= '0;
        err_q   <= 1'b0;
      end else if (reject_start) begin
        err_q <= 1'b1;
      end
      if (state == LOAD_LO && in_valid) lo_byte <= in_data;
      if (state == LOAD_HI && in_valid) hi_byte <= in_data;
      if (state == WRITE) begin
        last_addr  <= cnt;
        last_wdata <= {hi_byte, lo_byte};
        if (!last_word) cnt <= cnt + 1'b1;
      end
      if (state == RUN && run_cnt != '1) run_cnt <= run_cnt + 1'b1;
    end
  end

  // Address/data are live during WRITE and otherwise show the last word written.
  assign mem_addr   = (state == WRITE) ? cnt : last_addr;
  assign mem_wdata  = (state == WRITE) ? {hi_byte, lo_byte} : last_wdata;
  assign err        = err_q;
  assign run_cycles = run_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (ADDR_W=4 so DEPTH=16, CYC_W=4 for saturation).
module tb_prog_loader;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_instr = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_rst;
  logic          halted = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] run_cycles;

  prog_loader #(.INSTR_W(16), .ADDR_W(AW), .CYC_W(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .num_instr(num_instr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .halted(halted), .busy(busy), .done(done),
    .err(err), .run_cycles(run_cycles)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int we_cnt = 0;
  int we_cyc [64];
  logic [15:0] mem_model [16];

  // Instruction-memory model captures every write pulse.
  always @(posedge CLK) begin
    cyc++;
    if (mem_we === 1'b1) begin
      mem_model[mem_addr] = mem_wdata;
      if (we_cnt < 64) we_cyc[we_cnt] = cyc;
      we_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_instr = n[AW:0];
    tick();
    start     = 1'b0;
    num_instr = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic gap5();
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (5) tick();
    check("gap_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int w0;
    #1;
    // Reset state
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_run_cycles", run_cycles, 0);
    RST = 1'b0;
    tick();

    // 1: single word, halted tied high
    halted = 1'b1;
    do_start(1);
    check("t1_in_ready", in_ready, 1);
    check("t1_busy", busy, 1);
    w0 = we_cnt;
    send_byte(8'h00);
    send_byte(8'hF0);
    check("t1_mem_we", mem_we, 1);
    check("t1_addr", mem_addr, 0);
    check("t1_wdata", mem_wdata, 16'hF000);
    tick();
    check("t1_we_count", we_cnt - w0, 1);
    check("t1_run_cpu_rst", cpu_rst, 0);
    check("t1_run_done", done, 0);
    check("t1_run_cnt0", run_cycles, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_busy_done", busy, 0);
    check("t1_run_cycles", run_cycles, 1);
    tick();
    check("t1_run_held", run_cycles, 1);
    check("t1_mem_we_idle", mem_we, 0);
    check("t1_addr_hold", mem_addr, 0);
    check("t1_wdata_hold", mem_wdata, 16'hF000);

    // 2: four words back-to-back
    halted = 1'b0;
    do_start(4);
    check("t2_cpu_rst_load", cpu_rst, 1);
    check("t2_done_clr", done, 0);
    w0 = we_cnt;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h10 + 8'(i));
      send_byte(8'hC0 + 8'(i));
    end
    check("t2_last_we", mem_we, 1);
    check("t2_last_addr", mem_addr, 3);
    check("t2_cpu_rst_write", cpu_rst, 1);
    tick();
    check("t2_cpu_rst_run", cpu_rst, 0);
    check("t2_we_count", we_cnt - w0, 4);
    for (int i = 0; i < 3; i++)
      check("t2_we_spacing", we_cyc[w0 + i + 1] - we_cyc[w0 + i], 3);
    check("t2_mem0", mem_model[0], 16'hC010);
    check("t2_mem1", mem_model[1], 16'hC111);
    check("t2_mem2", mem_model[2], 16'hC212);
    check("t2_mem3", mem_model[3], 16'hC313);
    tick();
    tick();
    halted = 1'b1;
    tick();
    check("t2_done", done, 1);
    check("t2_run_cycles", run_cycles, 3);

    // 3: two words with 5-cycle gaps between every byte
    halted = 1'b0;
    do_start(2);
    w0 = we_cnt;
    gap5(); send_byte(8'h12);
    gap5(); send_byte(8'h34);
    gap5(); send_byte(8'h56);
    check("t3_we_mid", we_cnt - w0, 1);
    gap5(); send_byte(8'h78);
    tick();
    check("t3_we_count", we_cnt - w0, 2);
    check("t3_mem0", mem_model[0], 16'h3412);
    check("t3_mem1", mem_model[1], 16'h7856);
    halted = 1'b1;
    tick();
    check("t3_done", done, 1);

    // 4: bad lengths flag err, good length clears it
    do_start(0);
    check("t4_err_n0", err, 1);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_cpu_rst", cpu_rst, 1);
    check("t4_idle_done", done, 0);
    do_start(17);
    check("t4_err_big", err, 1);
    check("t4_big_busy", busy, 0);
    do_start(1);
    check("t4_err_clr", err, 0);
    check("t4_busy", busy, 1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick();
    tick();
    check("t4_done", done, 1);
    check("t4_mem0", mem_model[0], 16'hBBAA);

    // 5: RST while waiting for the second word's high byte
    halted = 1'b0;
    do_start(2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("t5_in_load_hi", in_ready, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_in_ready", in_ready, 0);
    check("t5_mem_we", mem_we, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_cpu_rst", cpu_rst, 1);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_run_cycles", run_cycles, 0);
    check("t5_mem_kept", mem_model[0], 16'h2211);
    do_start(1);
    send_byte(8'h44);
    send_byte(8'h55);
    check("t5_reload_addr", mem_addr, 0);
    check("t5_reload_wdata", mem_wdata, 16'h5544);
    tick();
    halted = 1'b1;
    tick();
    check("t5_done_after", done, 1);

    // 6: run counter saturation
    halted = 1'b0;
    do_start(1);
    send_byte(8'h01);
    send_byte(8'h02);
    tick();
    repeat (20) tick();
    check("t6_sat", run_cycles, 15);
    check("t6_busy", busy, 1);
    check("t6_not_done", done, 0);
    halted = 1'b1;
    tick();
    check("t6_done", done, 1);
    check("t6_sat_done", run_cycles, 15);
    tick();
    check("t6_sat_held", run_cycles, 15);

    // 7: N == DEPTH fills every address
    halted = 1'b0;
    do_start(16);
    w0 = we_cnt;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      send_byte(8'hA0 + 8'(i));
    end
    check("t7_last_addr", mem_addr, 15);
    tick();
    check("t7_we_count", we_cnt - w0, 16);
    check("t7_run", cpu_rst, 0);
    check("t7_mem0", mem_model[0], 16'hA000);
    check("t7_mem15", mem_model[15], 16'hAF0F);
    check("t7_addr_hold", mem_addr, 15);
    halted = 1'b1;
    tick();
    check("t7_done", done, 1);
    check("t7_run_cycles", run_cycles, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
